instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-side responder for the control unit's fetch signals (PC_load, PC_inc, PC_en, MAR_load, IR_load).
- Holds the program counter, MAR, MDR, IR and a 256-word program memory.
- Presents the 24-bit command_word (opcode | op1 | op2) and the fullRegFlag status back to the control unit.
- Sits between the control unit and program storage; a host preloads the memory through a write port.

Parameters:
ADDR_WIDTH, 8, PC/MAR/memory address width; memory depth is 2**ADDR_WIDTH.
WORD_WIDTH, 24, instruction word width (three 8-bit fields).
RESET_PC, 0, PC value after reset.
STACK_DEPTH, 4, return-stack entries (used only with FETCH_STACK_EN).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
PC_load  input  ADDR_WIDTH  jump/call target address.
PC_inc  input  1  with PC_en: 1 = increment, 0 = load PC_load.
PC_en  input  1  PC update enable.
MAR_load  input  1  latch PC into MAR and start a memory read.
IR_load  input  1  copy MDR into IR.
prog_we  input  1  program memory write strobe.
prog_addr  input  ADDR_WIDTH  program write address.
prog_data  input  WORD_WIDTH  program write data.
call_push  input  1  push return address and jump (stack feature).
ret_pop  input  1  pop return address into PC (stack feature).
command_word  output  WORD_WIDTH  current IR contents.
fullRegFlag  output  2  [0] = IR valid, [1] = read pending.
pc_out  output  ADDR_WIDTH  current PC (debug/visibility).
stack_err  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (async, rst=1): PC=RESET_PC; MAR=0; MDR=0; IR=0; mdr_valid=0; pending=0; stack empty; stack_err=0; command_word=0; fullRegFlag=2'b00. Memory contents are not reset.
- PC update priority, highest first: rst > ret_pop > call_push > PC_en.
  - PC_en=1, PC_inc=1: PC <= PC+1, wrapping 2**ADDR_WIDTH-1 -> 0.
  - PC_en=1, PC_inc=0: PC <= PC_load.
  - PC_en=0: PC holds.
- Fetch sequence (cycle N = edge where MAR_load=1):
  - Edge N: MAR <= PC (pre-update value if PC_en is also high); pending <= 1; mdr_valid <= 0.
  - Edge N+1: MDR <= mem[MAR]; mdr_valid <= 1; pending <= 0.
  - IR_load at any edge with mdr_valid=1: IR <= MDR; IR-valid bit <= 1.
  - Minimum MAR_load-to-command_word latency: 3 edges.
- IR_load with mdr_valid=0: ignored; IR and IR-valid hold.
- MAR_load while pending=1: ignored; the in-flight read completes normally.
- MAR_load also clears the IR-valid bit. command_word keeps its old value until the next IR_load.
- fullRegFlag is registered: [1] = pending, [0] = IR valid.
- prog_we writes mem[prog_addr] <= prog_data at the edge. A read of the same address in the same cycle returns the old data (read-before-write).
- Reset mid-fetch aborts the read; pending and mdr_valid return to 0.

Optional Feature:
FETCH_STACK_EN
- Defined: STACK_DEPTH-entry LIFO return stack, no wrap.
  - call_push: push PC+1 (wrapped), then PC <= PC_load.
  - ret_pop: PC <= top entry; entry removed.
  - Push when full: stack and PC unchanged; stack_err <= 1.
  - Pop when empty: PC unchanged; stack_err <= 1.
  - call_push and ret_pop together: pop wins, push is dropped.
  - stack_err clears only on rst.
- Undefined: call_push and ret_pop are ignored; stack_err is tied 0; ports remain present.

Test Plan:
- Reset, then preload mem[0]=24'h010203 and mem[1]=24'h180405. MAR_load at edge N, IR_load at N+2 -> command_word=24'h010203 after N+2; fullRegFlag 2'b10 after N, 2'b00 after N+1, 2'b01 after N+2.
- PC=8'hFF, PC_en=1, PC_inc=1 -> PC=8'h00. PC_en=1, PC_inc=0, PC_load=8'h0A -> PC=8'h0A. PC_en=0 -> PC holds 8'h0A.
- IR_load one cycle after MAR_load (mdr_valid=0) -> IR unchanged. Second MAR_load while pending -> MAR unchanged, fetch completes from the original address.
- Assert rst between MAR_load and MDR capture -> all outputs 0, fullRegFlag=2'b00; the following IR_load is ignored.
- prog_we to MAR's address in the MDR capture cycle: old word=24'h000000, new=24'hABCDEF -> MDR=24'h000000. Refetch -> 24'hABCDEF.
- FETCH_STACK_EN, STACK_DEPTH=4:
  - PC=3, call_push with PC_load=8'h0B -> PC=8'h0B.
  - ret_pop -> PC=8'h04.
  - 5 pushes -> stack_err=1 and the 5th push is ignored.
  - Pop from an empty stack -> stack_err=1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, MAR/MDR/IR fetch pipeline and program memory with host write port.
// Optional return stack enabled by defining FETCH_STACK_EN.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    WORD_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PC_load,
  input  logic                  PC_inc,
  input  logic                  PC_en,
  input  logic                  MAR_load,
  input  logic                  IR_load,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [WORD_WIDTH-1:0] prog_data,
  input  logic                  call_push,
  input  logic                  ret_pop,
  output logic [WORD_WIDTH-1:0] command_word,
  output logic [1:0]            fullRegFlag,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  stack_err
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [WORD_WIDTH-1:0] mdr_q, mdr_d, ir_q, ir_d;
  logic                  mdr_v_q, mdr_v_d, pend_q, pend_d, irv_q, irv_d;
  logic [WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_WIDTH-1:0] mem_rd;

  // Memory is not reset; old data is read when the same address is written.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end
  assign mem_rd = mem_q[mar_q];

`ifdef FETCH_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam logic [SPW:0] FULL = (SPW+1)'(STACK_DEPTH);

  logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0] stk_q, stk_d;
  logic [SPW:0]                           sp_q, sp_d;
  logic                                   err_q, err_d;

  always_comb begin
    pc_d  = pc_q;
    stk_d = stk_q;
    sp_d  = sp_q;
    err_d = err_q;
    // Pop has priority over push; a failed stack op leaves PC untouched.
    if (ret_pop) begin
      if (sp_q == '0) err_d = 1'b1;
      else begin
        pc_d = stk_q[SPW'(sp_q - 1'b1)];
        sp_d = sp_q - 1'b1;
      end
    end else if (call_push) begin
      if (sp_q == FULL) err_d = 1'b1;
      else begin
        stk_d[SPW'(sp_q)] = pc_q + 1'b1;
        sp_d              = sp_q + 1'b1;
        pc_d              = PC_load;
      end
    end else if (PC_en) begin
      pc_d = PC_inc ? pc_q + 1'b1 : PC_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign stack_err = err_q;
`else
  logic unused_stack;
  assign unused_stack = call_push ^ ret_pop ^ (STACK_DEPTH > 0);

  always_comb begin
    pc_d = pc_q;
    if (PC_en) pc_d = PC_inc ? pc_q + 1'b1 : PC_load;
  end

  assign stack_err = 1'b0;
`endif

  always_comb begin
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    mdr_v_d = mdr_v_q;
    pend_d  = pend_q;
    irv_d   = irv_q;
    if (IR_load && mdr_v_q) begin
      ir_d  = mdr_q;
      irv_d = 1'b1;
    end
    // A pending read always completes; MAR_load during it is dropped.
    if (pend_q) begin
      mdr_d   = mem_rd;
      mdr_v_d = 1'b1;
      pend_d  = 1'b0;
    end else if (MAR_load) begin
      mar_d   = pc_q;
      pend_d  = 1'b1;
      mdr_v_d = 1'b0;
      irv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      mdr_v_q <= 1'b0;
      pend_q  <= 1'b0;
      irv_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      mdr_v_q <= mdr_v_d;
      pend_q  <= pend_d;
      irv_q   <= irv_d;
    end
  end

  assign command_word = ir_q;
  assign fullRegFlag  = {pend_q, irv_q};
  assign pc_out       = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic vs. a reference model.
module tb_instr_fetch_unit;
`ifdef FETCH_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  PC_load = '0, prog_addr = '0;
  logic        PC_inc = 0, PC_en = 0, MAR_load = 0, IR_load = 0, prog_we = 0;
  logic        call_push = 0, ret_pop = 0;
  logic [23:0] prog_data = '0;
  logic [23:0] command_word;
  logic [1:0]  fullRegFlag;
  logic [7:0]  pc_out;
  logic        stack_err;

  int checks = 0, failures = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .PC_load(PC_load), .PC_inc(PC_inc), .PC_en(PC_en),
    .MAR_load(MAR_load), .IR_load(IR_load), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .call_push(call_push), .ret_pop(ret_pop),
    .command_word(command_word), .fullRegFlag(fullRegFlag), .pc_out(pc_out),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_pc, m_mar;
  logic [23:0] m_mdr, m_ir;
  bit          m_mv, m_pend, m_irv, m_err;
  logic [7:0]  m_stk[$];
  logic [23:0] m_mem[256];

  task automatic model_reset();
    m_pc = 8'h00; m_mar = 8'h00; m_mdr = '0; m_ir = '0;
    m_mv = 0; m_pend = 0; m_irv = 0; m_err = 0;
    m_stk.delete();
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic step();
    logic [7:0]  n_pc = m_pc, n_mar = m_mar;
    logic [23:0] n_mdr = m_mdr, n_ir = m_ir;
    bit          n_mv = m_mv, n_pend = m_pend, n_irv = m_irv;
    if (STK && ret_pop) begin
      if (m_stk.size() == 0) m_err = 1;
      else n_pc = m_stk.pop_back();
    end else if (STK && call_push) begin
      if (m_stk.size() == 4) m_err = 1;
      else begin
        m_stk.push_back(m_pc + 8'd1);
        n_pc = PC_load;
      end
    end else if (PC_en) begin
      n_pc = PC_inc ? m_pc + 8'd1 : PC_load;
    end
    if (IR_load && m_mv) begin n_ir = m_mdr; n_irv = 1; end
    if (m_pend) begin
      n_mdr = m_mem[m_mar]; n_mv = 1; n_pend = 0;
    end else if (MAR_load) begin
      n_mar = m_pc; n_pend = 1; n_mv = 0; n_irv = 0;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
    @(posedge clk); #1;
    m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir;
    m_mv = n_mv; m_pend = n_pend; m_irv = n_irv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [23:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    step();
    prog_we = 0;
  endtask

  task automatic fetch_at(input logic [7:0] a);
    PC_en = 1; PC_inc = 0; PC_load = a; step(); PC_en = 0;
    MAR_load = 1; step(); MAR_load = 0;
    step();
    IR_load = 1; step(); IR_load = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc_out); end
    checks++; if (command_word !== 24'h0) begin failures++; $display("FAIL reset_cw got=%h exp=000000", command_word); end
    checks++; if (fullRegFlag !== 2'b00) begin failures++; $display("FAIL reset_flag got=%b exp=00", fullRegFlag); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", stack_err); end
  endtask

  task automatic preload();
    for (int a = 0; a < 256; a++) write_mem(a[7:0], 24'($urandom));
    write_mem(8'h00, 24'h010203);
    write_mem(8'h01, 24'h180405);
    write_mem(8'h20, 24'h000000);
  endtask

  task automatic test_basic_fetch();
    MAR_load = 1; step(); MAR_load = 0;
    checks++; if (fullRegFlag !== 2'b10) begin failures++; $display("FAIL fetch_flag_n got=%b exp=10", fullRegFlag); end
    step();
    checks++; if (fullRegFlag !== 2'b00) begin failures++; $display("FAIL fetch_flag_n1 got=%b exp=00", fullRegFlag); end
    IR_load = 1; step(); IR_load = 0;
    checks++; if (command_word !== 24'h010203) begin failures++; $display("FAIL fetch_cw got=%h exp=010203", command_word); end
    checks++; if (fullRegFlag !== 2'b01) begin failures++; $display("FAIL fetch_flag_n2 got=%b exp=01", fullRegFlag); end
  endtask

  task automatic test_pc_update();
    PC_en = 1; PC_inc = 0; PC_load = 8'hFF; step();
    checks++; if (pc_out !== 8'hFF) begin failures++; $display("FAIL pc_load_ff got=%h exp=ff", pc_out); end
    PC_inc = 1; step();
    checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL pc_wrap got=%h exp=00", pc_out); end
    PC_inc = 0; PC_load = 8'h0A; step();
    checks++; if (pc_out !== 8'h0A) begin failures++; $display("FAIL pc_load_0a got=%h exp=0a", pc_out); end
    PC_en = 0; PC_load = 8'h77; step(); step();
    checks++; if (pc_out !== 8'h0A) begin failures++; $display("FAIL pc_hold got=%h exp=0a", pc_out); end
  endtask

  task automatic test_ignored_ops();
    PC_en = 1; PC_inc = 0; PC_load = 8'h01; step();
    PC_en = 0; MAR_load = 1; step();
    // Early IR_load and a second MAR_load after a PC change must both be dropped.
    IR_load = 1; PC_en = 1; PC_load = 8'h00; step();
    IR_load = 0; MAR_load = 0; PC_en = 0;
    checks++; if (command_word !== 24'h010203) begin failures++; $display("FAIL early_irload got=%h exp=010203", command_word); end
    checks++; if (fullRegFlag !== 2'b00) begin failures++; $display("FAIL pending_marload_flag got=%b exp=00", fullRegFlag); end
    IR_load = 1; step(); IR_load = 0;
    checks++; if (command_word !== 24'h180405) begin failures++; $display("FAIL orig_addr_cw got=%h exp=180405", command_word); end
  endtask

  task automatic test_reset_midfetch();
    fetch_at(8'h01);
    MAR_load = 1; step(); MAR_load = 0;
    #2 rst = 1'b1;
    #1;
    checks++; if (command_word !== 24'h0 || pc_out !== 8'h00 || fullRegFlag !== 2'b00 || stack_err !== 1'b0) begin
      failures++; $display("FAIL midfetch_reset got cw=%h pc=%h flag=%b err=%b exp all zero", command_word, pc_out, fullRegFlag, stack_err);
    end
    model_reset();
    #1 rst = 1'b0;
    IR_load = 1; step(); IR_load = 0;
    checks++; if (command_word !== 24'h0 || fullRegFlag !== 2'b00) begin
      failures++; $display("FAIL post_reset_irload got cw=%h flag=%b exp=000000/00", command_word, fullRegFlag);
    end
  endtask

  task automatic test_rbw();
    fetch_at(8'h01);
    PC_en = 1; PC_inc = 0; PC_load = 8'h20; step(); PC_en = 0;
    MAR_load = 1; step(); MAR_load = 0;
    prog_we = 1; prog_addr = 8'h20; prog_data = 24'hABCDEF; step(); prog_we = 0;
    IR_load = 1; step(); IR_load = 0;
    checks++; if (command_word !== 24'h000000 || fullRegFlag !== 2'b01) begin
      failures++; $display("FAIL rbw_old got cw=%h flag=%b exp=000000/01", command_word, fullRegFlag);
    end
    fetch_at(8'h20);
    checks++; if (command_word !== 24'hABCDEF) begin failures++; $display("FAIL rbw_new got=%h exp=abcdef", command_word); end
  endtask

`ifdef FETCH_STACK_EN
  task automatic test_stack();
    do_reset();
    PC_en = 1; PC_inc = 0; PC_load = 8'h03; step(); PC_en = 0;
    call_push = 1; PC_load = 8'h0B; step(); call_push = 0;
    checks++; if (pc_out !== 8'h0B) begin failures++; $display("FAIL call_pc got=%h exp=0b", pc_out); end
    ret_pop = 1; step(); ret_pop = 0;
    checks++; if (pc_out !== 8'h04) begin failures++; $display("FAIL ret_pc got=%h exp=04", pc_out); end
    for (int i = 0; i < 5; i++) begin
      call_push = 1; PC_load = 8'h40 + 8'(i); step();
      if (i < 4) begin
        checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL push_%0d_err got=%b exp=0", i, stack_err); end
      end
    end
    call_push = 0;
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b exp=1", stack_err); end
    checks++; if (pc_out !== 8'h43) begin failures++; $display("FAIL overflow_pc got=%h exp=43", pc_out); end
    do_reset();
    ret_pop = 1; step(); ret_pop = 0;
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", stack_err); end
    checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL underflow_pc got=%h exp=00", pc_out); end
  endtask
`else
  task automatic test_stack_disabled();
    PC_en = 1; PC_inc = 0; PC_load = 8'h12; step(); PC_en = 0;
    call_push = 1; PC_load = 8'h55; step(); call_push = 0;
    checks++; if (pc_out !== 8'h12) begin failures++; $display("FAIL nostack_push_pc got=%h exp=12", pc_out); end
    ret_pop = 1; step(); ret_pop = 0;
    checks++; if (pc_out !== 8'h12 || stack_err !== 1'b0) begin
      failures++; $display("FAIL nostack_pop got pc=%h err=%b exp=12/0", pc_out, stack_err);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      PC_en     = ($urandom_range(3) == 0);
      PC_inc    = 1'($urandom);
      PC_load   = 8'($urandom);
      MAR_load  = ($urandom_range(2) == 0);
      IR_load   = 1'($urandom);
      prog_we   = ($urandom_range(7) == 0);
      prog_addr = 8'($urandom_range(3));
      prog_data = 24'($urandom);
      call_push = ($urandom_range(9) == 0);
      ret_pop   = ($urandom_range(9) == 0);
      step();
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, pc_out, m_pc); end
      checks++; if (command_word !== m_ir) begin failures++; $display("FAIL rnd_cw c=%0d got=%h exp=%h", c, command_word, m_ir); end
      checks++; if (fullRegFlag !== {m_pend, m_irv}) begin failures++; $display("FAIL rnd_flag c=%0d got=%b exp=%b", c, fullRegFlag, {m_pend, m_irv}); end
      checks++; if (stack_err !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, stack_err, m_err); end
    end
    {PC_en, MAR_load, IR_load, prog_we, call_push, ret_pop} = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    preload();
    test_basic_fetch();
    test_pc_update();
    test_ignored_ops();
    test_reset_midfetch();
    test_rbw();
`ifdef FETCH_STACK_EN
    test_stack();
`else
    test_stack_disabled();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
